// File: rtl/cfg_shadow_chain_pkg.sv
// Shared sizing helpers and frame-state encodings for the config shadow chain.
// Sizing is resolved at elaboration; no storage lives here.
package cfg_shadow_chain_pkg;

    typedef enum logic [1:0] {
        FRM_EMPTY   = 2'd0,
        FRM_PARTIAL = 2'd1,
        FRM_FULL    = 2'd2
    } frame_state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic int calc_beats(input int conf_w, input int lanes);
        return (conf_w + lanes - 1) / lanes;
    endfunction

    function automatic int calc_sh_w(input int conf_w, input int lanes);
        return calc_beats(conf_w, lanes) * lanes;
    endfunction

endpackage

// File: rtl/cfg_shadow_chain_ctrl.sv
// Beat counter, frame-state decode and one-action-per-cycle arbitration (set > load_rb > cen).
// Strobes are combinational from the current count; no backpressure, every request is acted on or dropped.
module cfg_shadow_chain_ctrl
    import cfg_shadow_chain_pkg::*;
#(
    parameter int BEATS = 48,
    parameter int CNT_W = clog2(BEATS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic cen_i,
    input  logic set_i,
    input  logic load_rb_i,
    output logic do_shift_o,
    output logic do_load_o,
    output logic do_commit_o,
    output logic cfg_valid_o,
    output logic cfg_err_o,
    output logic frame_full_o
);

    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             cfg_err_q, cfg_err_d;
    frame_state_e     state;

    always_comb begin
        state = FRM_PARTIAL;
        if (cnt_q == '0) begin
            state = FRM_EMPTY;
        end else if (cnt_q == BEATS_C) begin
            state = FRM_FULL;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        cfg_valid_d = cfg_valid_q;
        cfg_err_d   = cfg_err_q;
        do_shift_o  = 1'b0;
        do_load_o   = 1'b0;
        do_commit_o = 1'b0;
        if (set_i) begin
            cnt_d = '0;
            if (state == FRM_FULL) begin
                do_commit_o = 1'b1;
                cfg_valid_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (load_rb_i) begin
            do_load_o = 1'b1;
            cnt_d     = BEATS_C;
        end else if (cen_i) begin
            // Beats beyond a full frame are pass-through only; the count saturates.
            do_shift_o = 1'b1;
            if (state != FRM_FULL) begin
                cnt_d = cnt_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_valid_o  = cfg_valid_q;
    assign cfg_err_o    = cfg_err_q;
    assign frame_full_o = (state == FRM_FULL);

endmodule

// File: rtl/cfg_shadow_chain.sv
// Multi-lane config shift chain with shadow/active registers, commit, readback and downstream pass-through.
// conf_out updates 1 cycle after a full-frame set_in; no backpressure, the chain shifts whenever cen is high.
module cfg_shadow_chain
    import cfg_shadow_chain_pkg::*;
#(
    parameter int CONF_W = 48,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              set_in,
    input  logic              load_rb,
    input  logic [LANES-1:0]  shift_in,
    output logic [LANES-1:0]  shift_out,
    output logic [CONF_W-1:0] conf_out,
    output logic              cfg_valid,
    output logic              cfg_err,
    output logic              frame_full
);

    localparam int BEATS = calc_beats(CONF_W, LANES);
    localparam int SH_W  = calc_sh_w(CONF_W, LANES);
    localparam int CNT_W = clog2(BEATS + 1);

    logic [SH_W-1:0]   shadow_q, shadow_d, shadow_shifted;
    logic [CONF_W-1:0] active_q, active_d;
    logic              do_shift, do_load, do_commit;

    cfg_shadow_chain_ctrl #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .cen_i        (cen),
        .set_i        (set_in),
        .load_rb_i    (load_rb),
        .do_shift_o   (do_shift),
        .do_load_o    (do_load),
        .do_commit_o  (do_commit),
        .cfg_valid_o  (cfg_valid),
        .cfg_err_o    (cfg_err),
        .frame_full_o (frame_full)
    );

    // A single-beat chain has no retained upper slice to shift down.
    generate
        if (SH_W == LANES) begin : g_single_beat
            assign shadow_shifted = shift_in;
        end else begin : g_multi_beat
            assign shadow_shifted = {shift_in, shadow_q[SH_W-1:LANES]};
        end
    endgenerate

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (do_commit) begin
            active_d = shadow_q[CONF_W-1:0];
        end else if (do_load) begin
            shadow_d               = '0;
            shadow_d[CONF_W-1:0]   = active_q;
        end else if (do_shift) begin
            shadow_d = shadow_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign shift_out = shadow_q[LANES-1:0];
    assign conf_out  = active_q;

endmodule
